pipe_skid_stage: RTL and testbench
==================================

// Module: pipe_skid_stage
// PURPOSE
//  Parametrised elastic pipeline-stage register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a DATA_W payload with a valid/ready handshake and a 2-entry skid buffer, so in_ready_o has no combinational path from out_ready_i.
//  Supports pipeline flush (bubble insertion) and a global halt that freezes the stage during a D-cache miss.
//  Also keeps a saturating back-pressure counter for performance debug.
// PARAMETERS
//  DATA_W     64   payload width in bits (e.g. pc+inst = 64 for IF/ID)
//  FLUSH_VAL  0    value loaded into every payload register on reset/flush (DATA_W wide)
//  CNT_W      16   width of the back-pressure stall counter
// PORTS
//  clk_i        in   1       clock; all state changes on rising edge
//  rst_i        in   1       reset, synchronous, active-low
//  flush_i      in   1       discard all held entries (branch/jump taken)
//  halt_i       in   1       global freeze (cache miss); overrides flush and handshakes
//  in_valid_i   in   1       upstream payload valid
//  in_ready_o   out  1       stage can accept; registered
//  in_data_i    in   DATA_W  upstream payload
//  out_valid_o  out  1       downstream payload valid
//  out_ready_i  in   1       downstream accepts
//  out_data_o   out  DATA_W  payload; equals main register
//  occ_o        out  2       occupancy 0..2
//  stall_cnt_o  out  CNT_W   cycles with out_valid_o=1, out_ready_i=0, halt_i=0; saturates at all-ones
// BEHAVIOUR
//  - Reset (rst_i=0 at edge):
//    - state EMPTY; main and skid registers <= FLUSH_VAL.
//    - out_valid_o=0, in_ready_o=1, occ_o=0, stall_cnt_o=0.
//    - Reset beats halt and flush; inputs are ignored that cycle.
//  - in_fire  = in_valid_i & in_ready_o & ~halt_i.
//  - out_fire = out_valid_o & out_ready_i & ~halt_i.
//  - State machine (occ_o encodes state: EMPTY=0, ONE=1, FULL=2):
//    - EMPTY: in_fire -> ONE, main<=in_data_i.
//    - ONE:
//      - in_fire & out_fire -> ONE, main<=in_data_i.
//      - in_fire & ~out_fire -> FULL, skid<=in_data_i.
//      - ~in_fire & out_fire -> EMPTY.
//    - FULL: in_ready_o=0 (no in_fire possible); out_fire -> ONE, main<=skid.
//  - out_valid_o = (state!=EMPTY).
//  - in_ready_o = (state!=FULL), driven from the registered state only.
//  - Latency: 1 cycle in->out when EMPTY and downstream ready; 1 item per cycle throughput.
//  - Ordering is strict FIFO; no entry is duplicated or dropped except by flush.
//  - halt_i=1: all registers hold (incl. stall_cnt_o); flush_i is ignored; outputs stay stable.
//  - flush_i=1 & halt_i=0:
//    - Next state EMPTY; main and skid <= FLUSH_VAL.
//    - An in_fire that same cycle is discarded.
//    - An out_fire that same cycle still counts as consumed by downstream.
//  - stall_cnt_o increments by 1 per qualifying cycle; it holds at 2^CNT_W-1 and never wraps.
//  - When EMPTY, out_data_o=FLUSH_VAL (bubble = NOP when FLUSH_VAL=0).
// TESTING
//  1. Reset: hold rst_i=0 2 cycles with in_valid_i=1
//     -> out_valid_o=0, out_data_o=0, in_ready_o=1, occ_o=0, stall_cnt_o=0.
//  2. Streaming: out_ready_i=1, push 0x1..0x8 on consecutive cycles
//     -> same sequence on out_data_o, each 1 cycle later, in_ready_o never drops.
//  3. Back-pressure: out_ready_i=0, push A,B,C
//     -> A,B accepted, occ_o=2, in_ready_o=0, C held upstream, stall_cnt_o climbs.
//     Then release -> A,B,C delivered in order.
//  4. Flush: occ_o=2 (A,B), flush_i=1 with in_valid_i=1 data D
//     -> next cycle occ_o=0, out_valid_o=0, out_data_o=0, D not delivered.
//  5. Halt over flush: occ_o=1, halt_i=1 & flush_i=1 & out_ready_i=1 for 3 cycles
//     -> out_data_o, occ_o, stall_cnt_o unchanged; after halt drops, the item is delivered.
//  6. Counter saturation: CNT_W=4, out_valid_o=1, out_ready_i=0 for 20 cycles
//     -> stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// The stage holds up to two payloads in strict FIFO order. in_ready_o is a
// register, so there is no combinational path from out_ready_i back upstream.
// Flush inserts a bubble, halt freezes everything, and a saturating counter
// records cycles of downstream back-pressure.
module pipe_skid_stage #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = {DATA_W{1'b0}},
    parameter int                 CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              halt_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                out_valid_q;
    logic                in_ready_q;
    logic                in_fire_s;
    logic                out_fire_s;

    assign in_fire_s  = in_valid_i & in_ready_q & ~halt_i;
    assign out_fire_s = out_valid_q & out_ready_i & ~halt_i;

    // Next-state and payload selection; main is refilled with FLUSH_VAL
    // whenever the stage drains so an empty stage always presents a bubble.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (halt_i) begin
            state_d = state_q;
        end else if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = FLUSH_VAL;
            skid_d  = FLUSH_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_d = in_data_i;
                    end else if (in_fire_s) begin
                        state_d = ST_FULL;
                        skid_d  = in_data_i;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                        main_d  = FLUSH_VAL;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = FLUSH_VAL;
                    skid_d  = FLUSH_VAL;
                end
            endcase
        end
    end

    // Back-pressure counter: counts stalled-but-valid cycles, sticks at max.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready_i && !halt_i && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // State, payload and handshake registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_EMPTY;
            main_q      <= FLUSH_VAL;
            skid_q      <= FLUSH_VAL;
            stall_q     <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_q     <= stall_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_FULL);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;
    assign occ_o       = state_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus random
// traffic, checked against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_skid_stage;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              halt_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occ_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    int checks = 0;
    int passed = 0;

    pipe_skid_stage #(
        .DATA_W   (DATA_W),
        .FLUSH_VAL({DATA_W{1'b0}}),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .halt_i     (halt_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .occ_o      (occ_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: contents of the stage as a FIFO, plus the stall count.
    logic [DATA_W-1:0] held[$];
    int                stall_m = 0;
    logic [DATA_W-1:0] prev_out_data;

    // Monitor: apply each clock edge to the model, then compare DUT outputs.
    initial begin
        logic [DATA_W-1:0] item;
        bit in_fire, out_fire;
        forever begin
            @(posedge clk_i);
            if (!rst_i) begin
                held.delete();
                stall_m = 0;
            end else if (!halt_i) begin
                in_fire  = in_valid_i && (held.size() < 2);
                out_fire = (held.size() > 0) && out_ready_i;
                if ((held.size() > 0) && !out_ready_i && stall_m < (1 << CNT_W) - 1)
                    stall_m++;
                if (out_fire) begin
                    item = held.pop_front();
                    check("deliver", prev_out_data, item);
                end
                if (flush_i) held.delete();
                else if (in_fire) held.push_back(in_data_i);
            end
            #2;
            check("occ", 64'(occ_o), 64'(held.size()));
            check("out_valid", 64'(out_valid_o), 64'(held.size() > 0));
            check("in_ready", 64'(in_ready_o), 64'(held.size() < 2));
            check("out_data", out_data_o, (held.size() > 0) ? held[0] : 64'h0);
            check("stall_cnt", 64'(stall_cnt_o), 64'(stall_m));
            prev_out_data = out_data_o;
        end
    end

    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic ordy,
                       input logic fl, input logic ht);
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = ordy;
        flush_i     = fl;
        halt_i      = ht;
        @(negedge clk_i);
    endtask

    // Driver: directed scenarios followed by random traffic.
    initial begin
        rst_i = 1'b0;
        cyc(1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 64'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        rst_i = 1'b1;

        // Streaming 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Back-pressure: A,B fill the stage, C waits; long stall saturates counter.
        cyc(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
        repeat (20) cyc(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Flush with a full stage and a concurrent push of D.
        cyc(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hD, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Halt overrides flush and handshake; item survives.
        cyc(1'b1, 64'hE, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 64'hF, 1'b1, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            rst_i = ($urandom_range(0, 99) != 0);
            cyc($urandom_range(0, 3) != 0, {$urandom, $urandom},
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0);
        end
        rst_i = 1'b1;
        repeat (3) cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
